// File: rtl/cnu6_ib_ram_loader_if.sv
// ----------------------------------------------------------------------------
// cnu6_ib_ram_loader_if
// Groups the strobes from the CNU6 write FSM, the IB ROM read port, the LUT RAM
// write ports and the loader status flags into one bundle.
//   master : write FSM / ROM / RAM side (drives strobes and rom_rdata)
//   slave  : cnu6_ib_ram_loader (drives ROM address, RAM writes, status)
// ----------------------------------------------------------------------------
interface cnu6_ib_ram_loader_if #(
    parameter int LOAD_CYCLE     = 32,
    parameter int DATA_WIDTH     = 4,
    parameter int ITER_MAX       = 5,
    parameter int ROM_ADDR_WIDTH = $clog2(ITER_MAX*LOAD_CYCLE)
);
    localparam int WADDR_W = $clog2(LOAD_CYCLE);
    localparam int ITER_W  = $clog2(ITER_MAX);

    // strobes from the write FSM
    logic                      rom_port_fetch;
    logic                      ram_mux_en;
    logic                      ram_write_en;
    logic                      iter_update;
    logic                      c6ib_rom_rst;
    logic                      iter_clr;
    // IB ROM port
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic [2*DATA_WIDTH+1:0]   rom_rdata;
    // LUT RAM bank write ports
    logic [WADDR_W-1:0]        ram_waddr;
    logic [DATA_WIDTH-1:0]     ram_wdata_b0;
    logic [DATA_WIDTH-1:0]     ram_wdata_b1;
    logic                      ram_we_b0;
    logic                      ram_we_b1;
    // status
    logic [ITER_W-1:0]         iter_cnt;
    logic                      load_done;
    logic                      load_abort;
    logic                      iter_overflow;
    logic                      parity_err;

    modport master (
        output rom_port_fetch, ram_mux_en, ram_write_en, iter_update,
               c6ib_rom_rst, iter_clr, rom_rdata,
        input  rom_addr, ram_waddr, ram_wdata_b0, ram_wdata_b1, ram_we_b0,
               ram_we_b1, iter_cnt, load_done, load_abort, iter_overflow,
               parity_err
    );

    modport slave (
        input  rom_port_fetch, ram_mux_en, ram_write_en, iter_update,
               c6ib_rom_rst, iter_clr, rom_rdata,
        output rom_addr, ram_waddr, ram_wdata_b0, ram_wdata_b1, ram_we_b0,
               ram_we_b1, iter_cnt, load_done, load_abort, iter_overflow,
               parity_err
    );
endinterface

// File: rtl/cnu6_ib_ram_loader.sv
// ----------------------------------------------------------------------------
// cnu6_ib_ram_loader
// Copies one iteration's IB-map table (LOAD_CYCLE ROM words) from the
// synchronous IB ROM into the two interleaved LUT RAM banks, driven by the
// strobes of the CNU6 write FSM, and tracks the iteration index that forms
// the ROM base address (iter_cnt*LOAD_CYCLE).
// Ports:
//   write_clk : sole clock
//   rstn      : asynchronous active-low reset
//   io_bus    : cnu6_ib_ram_loader_if.slave (strobes in, ROM addr/data,
//               bank write ports, iter_cnt, load_done/abort pulses,
//               sticky iter_overflow / parity_err)
// Build option: define CNU6_LOADER_PARITY_EN to check the even-parity bits of
// every written ROM word; otherwise parity_err is tied low.
// ----------------------------------------------------------------------------
module cnu6_ib_ram_loader #(
    parameter int LOAD_CYCLE     = 32,
    parameter int DATA_WIDTH     = 4,
    parameter int ITER_MAX       = 5,
    parameter int ROM_ADDR_WIDTH = $clog2(ITER_MAX*LOAD_CYCLE)
) (
    input  logic                  write_clk,
    input  logic                  rstn,
    cnu6_ib_ram_loader_if.slave   io_bus
);
    localparam int WA_W = $clog2(LOAD_CYCLE);
    localparam int IT_W = $clog2(ITER_MAX);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_COMMIT} state_t;

    state_t                    r_state, w_state_nxt;
    logic [WA_W-1:0]           r_fetch_cnt, w_fetch_nxt, w_fetch_inc;
    logic [WA_W-1:0]           r_wr_cnt, w_wr_nxt;
    logic [IT_W-1:0]           r_iter_cnt, w_iter_nxt;
    logic [ROM_ADDR_WIDTH-1:0] r_rom_addr, w_rom_addr_nxt;
    logic                      r_we, w_we;
    logic [WA_W-1:0]           r_waddr, w_waddr;
    logic [DATA_WIDTH-1:0]     r_wd0, r_wd1, w_wd0, w_wd1;
    logic                      r_done, w_done, r_abort, w_abort;
    logic                      r_ovf, w_ovf_set;

    // fetch_cnt is the ROM entry currently being presented; it saturates on
    // the last entry so the final WRITE cycle does not run into the next table.
    assign w_fetch_inc = (r_fetch_cnt == WA_W'(LOAD_CYCLE-1)) ? r_fetch_cnt
                                                              : r_fetch_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_fetch_nxt = r_fetch_cnt;
        w_wr_nxt    = r_wr_cnt;
        w_iter_nxt  = r_iter_cnt;
        w_we        = 1'b0;
        w_wd0       = '0;
        w_wd1       = '0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.c6ib_rom_rst) begin
                    w_fetch_nxt = '0;
                    w_wr_nxt    = '0;
                end
                if (io_bus.rom_port_fetch) begin
                    w_state_nxt = S_FETCH;
                    w_fetch_nxt = '0;
                    w_wr_nxt    = '0;
                end
            end
            S_FETCH: begin
                w_fetch_nxt = '0;
                if (!io_bus.iter_update) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (io_bus.ram_write_en) begin
                    // Entry 0 was addressed during FETCH, so its data arrives in
                    // the first WRITE cycle; step the address one ahead now so
                    // entry k is on rom_rdata during WRITE cycle k.
                    w_state_nxt = S_WRITE;
                    w_fetch_nxt = w_fetch_inc;
                end
            end
            S_WRITE: begin
                if (!io_bus.ram_write_en || !io_bus.iter_update) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    if (io_bus.ram_mux_en) begin
                        w_wd0 = io_bus.rom_rdata[DATA_WIDTH-1:0];
                        w_wd1 = io_bus.rom_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                    w_wr_nxt    = r_wr_cnt + 1'b1;
                    w_fetch_nxt = w_fetch_inc;
                    if (r_wr_cnt == WA_W'(LOAD_CYCLE-1))
                        w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
                if (r_iter_cnt < IT_W'(ITER_MAX-1))
                    w_iter_nxt = r_iter_cnt + 1'b1;
                else
                    w_ovf_set  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // new codeword: clear beats a simultaneous commit increment
        if (io_bus.iter_clr)
            w_iter_nxt = '0;
    end

    assign w_waddr        = w_we ? r_wr_cnt : '0;
    assign w_rom_addr_nxt = ROM_ADDR_WIDTH'(w_iter_nxt) * ROM_ADDR_WIDTH'(LOAD_CYCLE)
                          + ROM_ADDR_WIDTH'(w_fetch_nxt);

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_fetch_cnt <= '0;
            r_wr_cnt    <= '0;
            r_iter_cnt  <= '0;
            r_rom_addr  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wd0       <= '0;
            r_wd1       <= '0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_cnt <= w_fetch_nxt;
            r_wr_cnt    <= w_wr_nxt;
            r_iter_cnt  <= w_iter_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_we        <= w_we;
            r_waddr     <= w_waddr;
            r_wd0       <= w_wd0;
            r_wd1       <= w_wd1;
            r_done      <= w_done;
            r_abort     <= w_abort;
            r_ovf       <= r_ovf | w_ovf_set;
        end
    end

`ifdef CNU6_LOADER_PARITY_EN
    logic r_perr, w_perr_set;

    // even parity: the stored bit equals the XOR of its field
    assign w_perr_set = w_we &&
        (((^io_bus.rom_rdata[DATA_WIDTH-1:0])            != io_bus.rom_rdata[2*DATA_WIDTH]) ||
         ((^io_bus.rom_rdata[2*DATA_WIDTH-1:DATA_WIDTH]) != io_bus.rom_rdata[2*DATA_WIDTH+1]));

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) r_perr <= 1'b0;
        else       r_perr <= r_perr | w_perr_set;
    end

    assign io_bus.parity_err = r_perr;
`else
    // parity bits are deliberately left unread in this build
    logic w_unused_parity;
    assign w_unused_parity   = ^io_bus.rom_rdata[2*DATA_WIDTH+1:2*DATA_WIDTH];
    assign io_bus.parity_err = 1'b0;
`endif

    assign io_bus.rom_addr      = r_rom_addr;
    assign io_bus.ram_waddr     = r_waddr;
    assign io_bus.ram_wdata_b0  = r_wd0;
    assign io_bus.ram_wdata_b1  = r_wd1;
    assign io_bus.ram_we_b0     = r_we;
    assign io_bus.ram_we_b1     = r_we;
    assign io_bus.iter_cnt      = r_iter_cnt;
    assign io_bus.load_done     = r_done;
    assign io_bus.load_abort    = r_abort;
    assign io_bus.iter_overflow = r_ovf;
endmodule

// File: tb/tb_cnu6_ib_ram_loader.sv
// ----------------------------------------------------------------------------
// tb_cnu6_ib_ram_loader
// Directed load sequence over a randomly filled IB ROM. Expected RAM writes,
// ROM addresses, iteration index and flags come from a table-level model:
// load n of iteration i reads ROM[i*32 + k] and writes it to bank address k.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnu6_ib_ram_loader;
    localparam int LC = 32;
    localparam int DW = 4;
    localparam int IM = 5;
`ifdef CNU6_LOADER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic write_clk = 1'b0;
    logic rstn;

    cnu6_ib_ram_loader_if #(.LOAD_CYCLE(LC), .DATA_WIDTH(DW), .ITER_MAX(IM)) bus ();

    cnu6_ib_ram_loader #(.LOAD_CYCLE(LC), .DATA_WIDTH(DW), .ITER_MAX(IM)) dut (
        .write_clk (write_clk),
        .rstn      (rstn),
        .io_bus    (bus)
    );

    always #5 write_clk = ~write_clk;

    // synchronous IB ROM, one-cycle read latency
    logic [2*DW+1:0] rom [0:255];
    always @(posedge write_clk) bus.rom_rdata <= rom[bus.rom_addr];

    int n_cmp = 0;
    int n_err = 0;
    int iter_m = 0;
    bit ovf_m  = 1'b0;
    bit pe_m   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge write_clk);
        @(negedge write_clk);
    endtask

    function automatic bit bad_par(input logic [2*DW+1:0] w);
        return ((^w[DW-1:0]) != w[2*DW]) || ((^w[2*DW-1:DW]) != w[2*DW+1]);
    endfunction

    task automatic chk_no_write(input string tag);
        chk({tag, "_we0"}, 32'(bus.ram_we_b0), 0);
        chk({tag, "_we1"}, 32'(bus.ram_we_b1), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_no_write(tag);
        chk({tag, "_waddr"}, 32'(bus.ram_waddr), 0);
        chk({tag, "_wd0"},   32'(bus.ram_wdata_b0), 0);
        chk({tag, "_wd1"},   32'(bus.ram_wdata_b1), 0);
        chk({tag, "_raddr"}, 32'(bus.rom_addr), 0);
        chk({tag, "_iter"},  32'(bus.iter_cnt), 0);
        chk({tag, "_done"},  32'(bus.load_done), 0);
        chk({tag, "_abort"}, 32'(bus.load_abort), 0);
        chk({tag, "_ovf"},   32'(bus.iter_overflow), 0);
        chk({tag, "_perr"},  32'(bus.parity_err), 0);
    endtask

    // checks the write of table entry j (registered, visible one cycle later)
    task automatic chk_write(input int base, input int j, input bit mux);
        logic [2*DW+1:0] w;
        w = rom[base + j];
        chk("we0",   32'(bus.ram_we_b0), 1);
        chk("we1",   32'(bus.ram_we_b1), 1);
        chk("waddr", 32'(bus.ram_waddr), j);
        chk("wd0",   32'(bus.ram_wdata_b0), mux ? 32'(w[DW-1:0])    : 0);
        chk("wd1",   32'(bus.ram_wdata_b1), mux ? 32'(w[2*DW-1:DW]) : 0);
        if (PAR_EN && bad_par(w)) pe_m = 1'b1;
        chk("perr",  32'(bus.parity_err), 32'(pe_m));
    endtask

    // nwr < LC aborts after nwr writes; rst_at >= 0 pulls rstn in that WRITE cycle
    task automatic do_load(input int nwr, input bit rand_mux, input bit clr_commit, input int rst_at);
        int base;
        bit mux_hist [LC];
        base = iter_m * LC;
        bus.rom_port_fetch = 1'b1;
        bus.iter_update    = 1'b1;
        bus.ram_mux_en     = 1'b1;
        bus.ram_write_en   = 1'b0;
        cyc();                                        // FETCH
        chk("fetch_raddr", 32'(bus.rom_addr), base);
        chk_no_write("fetch");
        bus.rom_port_fetch = 1'b0;
        bus.ram_write_en   = 1'b1;
        for (int k = 0; k < LC; k++) begin
            cyc();                                    // WRITE cycle k
            chk("wr_raddr", 32'(bus.rom_addr), base + ((k + 1 < LC) ? k + 1 : LC - 1));
            if (k == 0) chk_no_write("wr0");
            else        chk_write(base, k - 1, mux_hist[k-1]);
            if (k == rst_at) begin
                rstn = 1'b0;
                #1;
                iter_m = 0; ovf_m = 1'b0; pe_m = 1'b0;
                chk_all_zero("rst");
                bus.ram_write_en = 1'b0;
                bus.iter_update  = 1'b0;
                cyc();
                rstn = 1'b1;
                cyc();
                chk_all_zero("post_rst");
                return;
            end
            if (k == nwr) begin
                bus.ram_write_en = 1'b0;
                cyc();                                // back in IDLE
                chk("abort_pulse", 32'(bus.load_abort), 1);
                chk_no_write("abort");
                chk("abort_iter", 32'(bus.iter_cnt), iter_m);
                cyc();
                chk("abort_clr", 32'(bus.load_abort), 0);
                return;
            end
            mux_hist[k]    = rand_mux ? bit'($urandom_range(0, 1)) : 1'b1;
            bus.ram_mux_en = mux_hist[k];
        end
        cyc();                                        // COMMIT
        chk_write(base, LC - 1, mux_hist[LC-1]);
        chk("done_early", 32'(bus.load_done), 0);
        bus.ram_write_en = 1'b0;
        bus.iter_clr     = clr_commit;
        cyc();                                        // IDLE
        if (iter_m < IM - 1) iter_m++;
        else                 ovf_m = 1'b1;
        if (clr_commit) iter_m = 0;
        chk("done", 32'(bus.load_done), 1);
        chk_no_write("commit_idle");
        chk("iter", 32'(bus.iter_cnt), iter_m);
        chk("ovf",  32'(bus.iter_overflow), 32'(ovf_m));
        bus.iter_clr = 1'b0;
        cyc();
        chk("done_clr", 32'(bus.load_done), 0);
    endtask

    initial begin
        logic [DW-1:0] b0, b1;
        for (int a = 0; a < 256; a++) begin
            b0 = DW'($urandom);
            b1 = DW'($urandom);
            rom[a] = {^b1, ^b0, b1, b0};
        end
        rom[LC + 7][2*DW+1] = ~rom[LC + 7][2*DW+1];   // iteration 1, entry 7: bad bank1 parity

        bus.rom_port_fetch = 1'b0;
        bus.ram_mux_en     = 1'b0;
        bus.ram_write_en   = 1'b0;
        bus.iter_update    = 1'b0;
        bus.c6ib_rom_rst   = 1'b0;
        bus.iter_clr       = 1'b0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        @(negedge write_clk);
        chk_all_zero("reset");
        cyc();
        rstn = 1'b1;
        cyc();
        chk_all_zero("idle");

        do_load(LC, 1'b0, 1'b0, -1);                  // iteration 0
        bus.c6ib_rom_rst = 1'b1;
        cyc();
        chk("romrst_raddr", 32'(bus.rom_addr), iter_m * LC);
        bus.c6ib_rom_rst = 1'b0;

        do_load($urandom_range(8, 20), 1'b0, 1'b0, -1);   // abort in iteration 1
        do_load(LC, 1'b1, 1'b0, -1);                  // restart iteration 1 at waddr 0

        // FETCH aborted by iter_update dropping
        bus.rom_port_fetch = 1'b1;
        bus.iter_update    = 1'b1;
        cyc();
        bus.rom_port_fetch = 1'b0;
        bus.iter_update    = 1'b0;
        cyc();
        chk("fabort_pulse", 32'(bus.load_abort), 1);
        chk("fabort_iter",  32'(bus.iter_cnt), iter_m);
        chk_no_write("fabort");
        cyc();
        chk("fabort_clr",   32'(bus.load_abort), 0);

        do_load(LC, 1'b1, 1'b0, -1);                  // iteration 2
        do_load(LC, 1'b0, 1'b0, -1);                  // iteration 3: addresses 96..127
        do_load(LC, 1'b1, 1'b0, -1);                  // iteration 4, commit at ITER_MAX-1
        do_load(LC, 1'b0, 1'b0, -1);                  // again at base 128
        do_load(LC, 1'b0, 1'b1, -1);                  // iter_clr with COMMIT
        chk("ovf_kept", 32'(bus.iter_overflow), 1);
        do_load(LC, 1'b1, 1'b0, 5);                   // reset in WRITE cycle 5
        do_load(LC, 1'b1, 1'b0, -1);                  // clean load after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cnu6_ib_ram_loader.md
Name: cnu6_ib_ram_loader

Overview:
- Downstream datapath stage of the CNU6 write-control FSM.
- Consumes that FSM's strobes (rom_port_fetch, ram_mux_en, ram_write_en, iter_update, c6ib_rom_rst).
- Fetches the current iteration's IB-map entries from a synchronous IB ROM and writes them into the two interleaved LUT RAM banks used by the CNU6 array, LOAD_CYCLE words per iteration.
- Tracks the iteration index used to form the ROM base address.

Parameters:
- LOAD_CYCLE, 32: words per bank per iteration (64 entries over 2 banks).
- DATA_WIDTH, 4: bits per IB-map entry.
- ITER_MAX, 5: number of iteration tables stored in ROM.
- ROM_ADDR_WIDTH, $clog2(ITER_MAX*LOAD_CYCLE): ROM address width.

Ports:
- write_clk  in  1  sole clock
- rstn  in  1  reset, asynchronous, active-low
- rom_port_fetch  in  1  from write FSM: prime ROM read
- ram_mux_en  in  1  from write FSM: select ROM data onto RAM write bus
- ram_write_en  in  1  from write FSM: RAM write window
- iter_update  in  1  from write FSM: update in progress
- c6ib_rom_rst  in  1  from write FSM: clear fetch/write counters
- iter_clr  in  1  synchronous clear of iter_cnt (new codeword)
- rom_addr  out  ROM_ADDR_WIDTH  IB ROM read address
- rom_rdata  in  2*DATA_WIDTH+2  ROM word: [DATA_WIDTH-1:0] bank0, next DATA_WIDTH bank1, top 2 bits parity
- ram_waddr  out  $clog2(LOAD_CYCLE)  shared write address of both banks
- ram_wdata_b0, ram_wdata_b1  out  DATA_WIDTH  bank write data (even/odd entries)
- ram_we_b0, ram_we_b1  out  1  bank write strobes
- iter_cnt  out  $clog2(ITER_MAX)  current iteration index
- load_done  out  1  one-cycle pulse after last word written
- load_abort  out  1  one-cycle pulse on truncated load
- iter_overflow  out  1  sticky, commit attempted at ITER_MAX-1
- parity_err  out  1  sticky ROM parity error

Behaviour:
- Reset (rstn low, async): state IDLE; fetch_cnt, wr_cnt, iter_cnt, rom_addr = 0; all strobes, pulses, sticky flags = 0.
- rom_addr = iter_cnt*LOAD_CYCLE + fetch_cnt, registered. ROM read latency is 1 cycle: rom_rdata reflects the address presented in the previous cycle.
- Entry mapping: entry 2k goes to bank0 addr k; entry 2k+1 goes to bank1 addr k.
- State IDLE:
  - c6ib_rom_rst high clears fetch_cnt and wr_cnt.
  - rom_port_fetch high moves to FETCH, with address base+0 presented.
- State FETCH (prime):
  - fetch_cnt holds at 0.
  - ram_write_en high moves to WRITE.
  - iter_update low moves to IDLE with load_abort pulse.
- State WRITE:
  - Each cycle: ram_we_b0 = ram_we_b1 = 1, ram_waddr = wr_cnt, wdata = rom_rdata fields.
  - wr_cnt increments; fetch_cnt increments, saturating at LOAD_CYCLE-1.
  - Entry k is written on WRITE cycle k, so LOAD_CYCLE writes take LOAD_CYCLE cycles.
  - Write at wr_cnt == LOAD_CYCLE-1 moves to COMMIT.
  - ram_write_en or iter_update low before then: no write that cycle, move to IDLE, load_abort pulse, iter_cnt unchanged.
  - ram_mux_en low in WRITE: wdata forced to 0, strobes still follow ram_write_en.
- State COMMIT (1 cycle):
  - load_done = 1.
  - iter_cnt +1 if below ITER_MAX-1; otherwise it holds and iter_overflow sets.
  - Then moves to IDLE. A new load needs rom_port_fetch again.
- iter_clr: clears iter_cnt next cycle in any state.
  - iter_clr in the same cycle as COMMIT: clear wins, iter_cnt = 0.
  - iter_clr does not clear iter_overflow; only rstn does.
- Strobes and data outputs are registered; all are 0 outside WRITE.
- rstn low mid-WRITE: everything clears immediately; no further strobes.

Optional Feature:
- Macro: CNU6_LOADER_PARITY_EN.
- Defined: on every WRITE cycle, check even parity of each bank field against rom_rdata[2*DATA_WIDTH] (bank0) and rom_rdata[2*DATA_WIDTH+1] (bank1). A mismatch sets parity_err (sticky until rstn). The write still occurs.
- Undefined: parity bits ignored, parity_err tied 0, no check logic.

Test Plan:
- Nominal load, iter_cnt=0:
  - Stimulus: rom_port_fetch 1 cycle, ram_mux_en, then ram_write_en for 32 cycles. ROM word at addr a has bank0=a[3:0], bank1=~a[3:0].
  - Required: 32 writes, waddr 0..31 with matching data; load_done 1 cycle after the write at waddr 31; iter_cnt=1.
- Iteration base:
  - Stimulus: four back-to-back full loads.
  - Required: on the 4th load, rom_addr runs 96..127; iter_cnt=4.
- Overflow:
  - Stimulus: a 6th load with ITER_MAX=5.
  - Required: addresses 128..159; iter_cnt stays 4; iter_overflow=1.
- Abort:
  - Stimulus: drop ram_write_en after 10 writes.
  - Required: load_abort pulse; iter_cnt unchanged; next load restarts at waddr 0.
- Reset and clear:
  - Stimulus: rstn low at WRITE cycle 5.
  - Required: strobes 0 the same cycle; all outputs 0.
  - Stimulus: iter_clr coinciding with COMMIT.
  - Required: iter_cnt=0.
- Parity (macro defined):
  - Stimulus: ROM word at waddr 7 with a flipped bank1 parity bit.
  - Required: parity_err=1 from the following cycle and held; all 32 writes still occur.
